dvp_frame_sequencer: RTL and testbench

Run-control sequencer for the DVP source path. It owns the line and frame counters and issues read requests to a synchronous-read frame buffer. It drives registered `href`/`hsync`/`vsync` aligned with the returned pixel data. It holds a runtime-writable timing register bank, shadowed at frame boundaries, and handles start, graceful stop, abort and N-frame bursts for simulation and bring-up.

---
 rtl/dvp_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_dvp_frame_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_sequencer.sv
// ----------------------------------------------------------------------------
// dvp_frame_sequencer
//   Run-control sequencer for the DVP source path. Owns the pixel/line
//   counters, issues raster-order read requests to a synchronous-read frame
//   buffer and drives registered href/hsync/vsync aligned with the returned
//   data (one cycle behind rd_en). Timing comes from a runtime-writable
//   register bank that is copied into shadow registers at every frame start.
//
// Ports
//   xclk, rst_n          clock, asynchronous active-low reset
//   start, stop, abort   run control pulses
//   num_frames           frames per run (0 = continuous), sampled on start
//   cfg_we/addr/wdata    timing bank write port (HF,HP,HB,HD,VF,VP,VB,VD)
//   rd_en, rd_addr       frame-buffer read request (rd_en combinational)
//   href, hsync, vsync   registered DVP timing
//   busy                 high while running
//   frame_done           combinational pulse in the last cycle of a frame
//   frame_idx            frames completed in the current run
// ----------------------------------------------------------------------------
module dvp_frame_sequencer #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned FRM_W  = 16,
    parameter int unsigned DEF_HF = 5,
    parameter int unsigned DEF_HP = 10,
    parameter int unsigned DEF_HB = 2,
    parameter int unsigned DEF_HD = 5,
    parameter int unsigned DEF_VF = 10,
    parameter int unsigned DEF_VP = 20,
    parameter int unsigned DEF_VB = 10,
    parameter int unsigned DEF_VD = 5,
    parameter bit          H_POL  = 1'b0,
    parameter bit          V_POL  = 1'b1
) (
    input  logic              xclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic [FRM_W-1:0]  num_frames,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              href,
    output logic              hsync,
    output logic              vsync,
    output logic              busy,
    output logic              frame_done,
    output logic [FRM_W-1:0]  frame_idx
);

    localparam int unsigned TW = CNT_W + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] bank [8];
    logic [CNT_W-1:0] sh   [8];
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] line;
    logic [FRM_W-1:0] nf_q;
    logic             stop_req;

    logic [TW-1:0] h_sync_end, h_act, h_total;
    logic [TW-1:0] v_sync_end, v_act, v_total;
    logic [TW-1:0] pix_w, line_w;
    logic          pix_last, line_last, eof;
    logic          in_win, in_hs, in_vs;
    logic          exit_c;
    logic          start_run;
    logic          reload;
    logic          wr_ok;

    // Reset contents of the timing bank, indexed like cfg_addr.
    function automatic logic [CNT_W-1:0] def_val(input int unsigned idx);
        case (idx)
            0:       def_val = CNT_W'(DEF_HF);
            1:       def_val = CNT_W'(DEF_HP);
            2:       def_val = CNT_W'(DEF_HB);
            3:       def_val = CNT_W'(DEF_HD);
            4:       def_val = CNT_W'(DEF_VF);
            5:       def_val = CNT_W'(DEF_VP);
            6:       def_val = CNT_W'(DEF_VB);
            default: def_val = CNT_W'(DEF_VD);
        endcase
    endfunction

    // Frame geometry from the shadow set, widened so the sums cannot wrap.
    assign h_sync_end = TW'(sh[0]) + TW'(sh[1]);
    assign h_act      = h_sync_end + TW'(sh[2]);
    assign h_total    = h_act + TW'(sh[3]);
    assign v_sync_end = TW'(sh[4]) + TW'(sh[5]);
    assign v_act      = v_sync_end + TW'(sh[6]);
    assign v_total    = v_act + TW'(sh[7]);

    assign pix_w     = TW'(pix);
    assign line_w    = TW'(line);
    assign pix_last  = (pix_w == h_total - TW'(1));
    assign line_last = (line_w == v_total - TW'(1));
    assign eof       = pix_last && line_last;
    assign in_win    = (pix_w >= h_act) && (line_w >= v_act);
    assign in_hs     = (pix_w >= TW'(sh[0])) && (pix_w < h_sync_end);
    assign in_vs     = (line_w >= TW'(sh[4])) && (line_w < v_sync_end);

    // Run ends after this frame on a stop request or when the burst count is reached.
    assign exit_c = stop_req || stop ||
                    ((nf_q != '0) && ((frame_idx + FRM_W'(1)) == nf_q));

    // Pulse, display and sync widths of zero are rejected (odd addresses).
    assign wr_ok = cfg_we && ((cfg_wdata != '0) || !cfg_addr[0]);

    // State register.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort dominates everything else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (eof && exit_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and internal strobes.
    always_comb begin
        rd_en      = 1'b0;
        frame_done = 1'b0;
        start_run  = 1'b0;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                start_run = start && !abort;
            end
            RUN: begin
                rd_en      = in_win;
                frame_done = eof && !abort;
                reload     = eof && !abort && !exit_c;
            end
            default: ;
        endcase
    end

    assign busy = (state == RUN);

    // Timing register bank.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                bank[i] <= def_val(i);
            end
        end else if (wr_ok) begin
            bank[cfg_addr] <= cfg_wdata;
        end
    end

    // Shadow copy taken at every frame start; sees the bank before any same-cycle write.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                sh[i] <= def_val(i);
            end
        end else if (start_run || reload) begin
            for (int unsigned i = 0; i < 8; i++) begin
                sh[i] <= bank[i];
            end
        end
    end

    // Raster counters and read address; everything restarts at zero on frame start or exit.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            pix     <= '0;
            line    <= '0;
            rd_addr <= '0;
        end else if ((state == RUN) && (state_nxt == RUN) && !eof) begin
            if (pix_last) begin
                pix  <= '0;
                line <= line + CNT_W'(1);
            end else begin
                pix <= pix + CNT_W'(1);
            end
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end else begin
            pix     <= '0;
            line    <= '0;
            rd_addr <= '0;
        end
    end

    // Run bookkeeping: burst length, stop request, completed frame count.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            nf_q      <= '0;
            stop_req  <= 1'b0;
            frame_idx <= '0;
        end else begin
            if (start_run) begin
                nf_q      <= num_frames;
                stop_req  <= 1'b0;
                frame_idx <= '0;
            end else begin
                if ((state == RUN) && stop) begin
                    stop_req <= 1'b1;
                end
                if (frame_done) begin
                    frame_idx <= frame_idx + FRM_W'(1);
                end
            end
        end
    end

    // DVP timing, registered from the same counters as rd_en so it lines up with RAM data.
    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            href  <= 1'b0;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
        end else begin
            href  <= rd_en;
            hsync <= ((state == RUN) && in_hs) ? H_POL : ~H_POL;
            vsync <= ((state == RUN) && in_vs) ? V_POL : ~V_POL;
        end
    end

endmodule

// File: tb/tb_dvp_frame_sequencer.sv
module tb_dvp_frame_sequencer;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned FRM_W  = 16;
    localparam bit          H_POL  = 1'b0;
    localparam bit          V_POL  = 1'b1;

    logic              xclk = 1'b0;
    logic              rst_n;
    logic              start, stop, abort;
    logic [FRM_W-1:0]  num_frames;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [CNT_W-1:0]  cfg_wdata;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              href, hsync, vsync, busy, frame_done;
    logic [FRM_W-1:0]  frame_idx;

    int errors = 0;
    int checks = 0;

    // Reference copy of the timing bank and per-frame read counts of the last run.
    int m_bank [8];
    int rd_cnt_q [$];

    dvp_frame_sequencer dut (
        .xclk       (xclk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .num_frames (num_frames),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .href       (href),
        .hsync      (hsync),
        .vsync      (vsync),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_idx  (frame_idx)
    );

    always #5 xclk = ~xclk;

    task automatic model_reset_bank();
        m_bank = '{5, 10, 2, 5, 10, 20, 10, 5};
    endtask

    // Zero writes to HP, HD, VP, VD leave the register alone.
    task automatic model_write(input int a, input int d);
        if (!(d == 0 && (a == 1 || a == 3 || a == 5 || a == 7))) m_bank[a] = d;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge xclk);
        start  = 1'b0;
        stop   = 1'b0;
        abort  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic program_cfg(input int v [8]);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            cfg_we    = 1'b1;
            cfg_addr  = 3'(i);
            cfg_wdata = CNT_W'(v[i]);
            model_write(i, v[i]);
        end
        next_cycle();
        next_cycle();
    endtask

    // Read address reached at raster position (p,l): whole window lines plus pixels so far.
    function automatic int addr_at(input int c [8], input int p, input int l);
        int hs;
        int vs;
        hs = c[0] + c[1] + c[2];
        vs = c[4] + c[5] + c[6];
        if (l < vs) return 0;
        return (l - vs) * c[3] + ((p > hs) ? (p - hs) : 0);
    endfunction

    // Runs one start..IDLE sequence and compares every cycle against the frame-level model.
    task automatic run_model(input int nf, input int stop_f,
                             input int w1f, input int w1a, input int w1d,
                             input int w2f, input int w2a, input int w2d,
                             input bit rnd_wr, output int frames);
        int cur [8];
        int f, ht, vt, cnt;
        bit stop_req, fin, pw, ph, pv, e_win, e_hs, e_vs, e_eof;
        logic [45:0] got, exp_v;
        next_cycle();
        num_frames = FRM_W'(nf);
        start      = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle_busy: got %b want 0", busy);
        end
        cur = m_bank;
        pw = 0; ph = 0; pv = 0;
        stop_req = 0; fin = 0; f = 0;
        rd_cnt_q.delete();
        while (!fin) begin
            f++;
            ht  = cur[0] + cur[1] + cur[2] + cur[3];
            vt  = cur[4] + cur[5] + cur[6] + cur[7];
            cnt = 0;
            for (int l = 0; l < vt; l++) begin
                for (int p = 0; p < ht; p++) begin
                    int k;
                    k = l * ht + p;
                    next_cycle();
                    num_frames = FRM_W'($urandom_range(1, 3));
                    if (w1f == f && k == 5) begin
                        cfg_we = 1'b1; cfg_addr = 3'(w1a); cfg_wdata = CNT_W'(w1d);
                    end else if (w2f == f && k == 5) begin
                        cfg_we = 1'b1; cfg_addr = 3'(w2a); cfg_wdata = CNT_W'(w2d);
                    end else if (rnd_wr && $urandom_range(0, 7) == 0) begin
                        cfg_we    = 1'b1;
                        cfg_addr  = 3'($urandom_range(0, 7));
                        cfg_wdata = CNT_W'($urandom_range(0, 4));
                    end
                    if (stop_f == f && k == (ht * vt) / 2) stop = 1'b1;
                    #1;
                    e_eof = (l == vt - 1) && (p == ht - 1);
                    e_win = (p >= cur[0] + cur[1] + cur[2]) && (l >= cur[4] + cur[5] + cur[6]);
                    e_hs  = (p >= cur[0]) && (p < cur[0] + cur[1]);
                    e_vs  = (l >= cur[4]) && (l < cur[4] + cur[5]);
                    got   = {rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx};
                    exp_v = {e_win, ADDR_W'(addr_at(cur, p, l)), pw,
                             (ph ? H_POL : ~H_POL), (pv ? V_POL : ~V_POL),
                             1'b1, e_eof, FRM_W'(f - 1)};
                    checks++;
                    if (got !== exp_v) begin
                        errors++;
                        $display("FAIL raster f=%0d l=%0d p=%0d got en=%b addr=%0d href=%b hs=%b vs=%b busy=%b done=%b idx=%0d want en=%b addr=%0d href=%b hs=%b vs=%b busy=1 done=%b idx=%0d",
                                 f, l, p, rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx,
                                 e_win, addr_at(cur, p, l), pw, (ph ? H_POL : ~H_POL),
                                 (pv ? V_POL : ~V_POL), e_eof, f - 1);
                    end
                    if (rd_en === 1'b1) cnt++;
                    if (stop) stop_req = 1;
                    pw = e_win; ph = e_hs; pv = e_vs;
                    if (e_eof) begin
                        rd_cnt_q.push_back(cnt);
                        if (stop_req || (nf != 0 && f == nf)) fin = 1;
                        else cur = m_bank;
                    end
                    if (cfg_we) model_write(int'(cfg_addr), int'(cfg_wdata));
                end
            end
            if (!fin && f >= 12) begin
                errors++;
                $display("FAIL run_bound: run still active after %0d frames", f);
                fin = 1;
            end
        end
        frames = f;
        next_cycle();
        #1;
        got   = {rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx};
        exp_v = {1'b0, ADDR_W'(0), pw, (ph ? H_POL : ~H_POL), (pv ? V_POL : ~V_POL),
                 1'b0, 1'b0, FRM_W'(f)};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL exit_edge: got %h want %h", got, exp_v);
        end
        next_cycle();
        #1;
        got   = {rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx};
        exp_v = {1'b0, ADDR_W'(0), 1'b0, ~H_POL, ~V_POL, 1'b0, 1'b0, FRM_W'(f)};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL idle_after_exit: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge xclk);
        #1;
        checks++;
        if ({href, hsync, vsync} !== {1'b0, ~H_POL, ~V_POL}) begin
            errors++;
            $display("FAIL reset_sync: got %b%b%b want %b%b%b", href, hsync, vsync, 1'b0, ~H_POL, ~V_POL);
        end
        checks++;
        if ({rd_en, rd_addr} !== {1'b0, ADDR_W'(0)}) begin
            errors++;
            $display("FAIL reset_rd: got en=%b addr=%0d want 0/0", rd_en, rd_addr);
        end
        checks++;
        if ({busy, frame_done, frame_idx} !== {1'b0, 1'b0, FRM_W'(0)}) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b idx=%0d want 0/0/0", busy, frame_done, frame_idx);
        end
        @(negedge xclk);
        rst_n = 1'b1;
        model_reset_bank();
        next_cycle();
    endtask

    task automatic test_basic_burst();
        int fr;
        program_cfg('{1, 2, 1, 4, 1, 1, 1, 3});
        run_model(2, 0, 0, 0, 0, 0, 0, 0, 1'b0, fr);
        checks++;
        if (fr !== 2 || rd_cnt_q.size() !== 2) begin
            errors++;
            $display("FAIL burst_frames: got %0d frames want 2", fr);
        end else begin
            checks++;
            if (rd_cnt_q[0] !== 12 || rd_cnt_q[1] !== 12) begin
                errors++;
                $display("FAIL burst_reads: got %0d,%0d want 12,12", rd_cnt_q[0], rd_cnt_q[1]);
            end
        end
    endtask

    task automatic test_random_runs();
        int v [8];
        int nf, fr;
        for (int it = 0; it < 5; it++) begin
            v = '{$urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(1, 6),
                  $urandom_range(0, 2), $urandom_range(1, 2), $urandom_range(0, 2), $urandom_range(1, 4)};
            program_cfg(v);
            nf = $urandom_range(1, 3);
            run_model(nf, 0, 0, 0, 0, 0, 0, 0, 1'b1, fr);
            checks++;
            if (fr !== nf) begin
                errors++;
                $display("FAIL random_frames it=%0d: got %0d want %0d", it, fr, nf);
            end
        end
    endtask

    task automatic test_stop();
        int fr;
        program_cfg('{1, 2, 1, 4, 1, 1, 1, 3});
        run_model(0, 3, 0, 0, 0, 0, 0, 0, 1'b0, fr);
        checks++;
        if (fr !== 3 || rd_cnt_q.size() !== 3) begin
            errors++;
            $display("FAIL stop_frames: got %0d want 3", fr);
        end
    endtask

    task automatic test_hd_change();
        int fr;
        program_cfg('{1, 2, 1, 4, 1, 1, 1, 3});
        run_model(0, 3, 1, 3, 6, 2, 3, 0, 1'b0, fr);
        checks++;
        if (rd_cnt_q.size() !== 3) begin
            errors++;
            $display("FAIL hd_change_frames: got %0d want 3", rd_cnt_q.size());
        end else begin
            checks++;
            if (rd_cnt_q[0] !== 12 || rd_cnt_q[1] !== 18 || rd_cnt_q[2] !== 18) begin
                errors++;
                $display("FAIL hd_change_reads: got %0d,%0d,%0d want 12,18,18",
                         rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        bit hit;
        program_cfg('{1, 2, 1, 4, 1, 1, 1, 3});
        next_cycle();
        num_frames = '0;
        start      = 1'b1;
        n   = 0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            next_cycle();
            if (n == 5) begin
                abort = 1'b1;
                hit   = 1;
            end
            #1;
            if (hit) begin
                checks++;
                if ({frame_done, rd_en, rd_addr} !== {1'b0, 1'b1, ADDR_W'(5)}) begin
                    errors++;
                    $display("FAIL abort_cycle: got done=%b en=%b addr=%0d want 0/1/5", frame_done, rd_en, rd_addr);
                end
            end else if (rd_en === 1'b1) begin
                n++;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: only %0d reads seen, want 5", n);
        end
        next_cycle();
        #1;
        checks++;
        if ({busy, rd_en, rd_addr, href} !== {1'b0, 1'b0, ADDR_W'(0), 1'b1}) begin
            errors++;
            $display("FAIL abort_exit: got busy=%b en=%b addr=%0d href=%b want 0/0/0/1", busy, rd_en, rd_addr, href);
        end
        next_cycle();
        #1;
        checks++;
        if ({href, hsync, vsync} !== {1'b0, ~H_POL, ~V_POL}) begin
            errors++;
            $display("FAIL abort_sync: got %b%b%b want %b%b%b", href, hsync, vsync, 1'b0, ~H_POL, ~V_POL);
        end
        // Abort landing exactly on the end-of-frame cycle.
        next_cycle();
        start = 1'b1;
        for (int i = 0; i < 48; i++) begin
            next_cycle();
            if (i == 47) begin
                abort = 1'b1;
                #1;
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_eof_done: got %b want 0", frame_done);
                end
            end
        end
        next_cycle();
        #1;
        checks++;
        if ({busy, frame_idx} !== {1'b0, FRM_W'(0)}) begin
            errors++;
            $display("FAIL abort_eof_exit: got busy=%b idx=%0d want 0/0", busy, frame_idx);
        end
        next_cycle();
    endtask

    task automatic test_start_abort();
        next_cycle();
        num_frames = FRM_W'(1);
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if ({busy, rd_en} !== 2'b00) begin
                errors++;
                $display("FAIL start_abort: cycle %0d got busy=%b en=%b want 0/0", i, busy, rd_en);
            end
        end
    endtask

    task automatic test_start_in_run();
        program_cfg('{1, 2, 1, 4, 1, 1, 1, 3});
        next_cycle();
        num_frames = '0;
        start      = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            next_cycle();
            if (i == 60) begin
                start      = 1'b1;
                num_frames = FRM_W'(1);
            end
            #1;
            if (i == 61) begin
                checks++;
                if ({busy, frame_idx} !== {1'b1, FRM_W'(1)}) begin
                    errors++;
                    $display("FAIL start_in_run: got busy=%b idx=%0d want 1/1", busy, frame_idx);
                end
            end
            if (i == 100) begin
                checks++;
                if ({busy, frame_idx} !== {1'b1, FRM_W'(2)}) begin
                    errors++;
                    $display("FAIL start_in_run_later: got busy=%b idx=%0d want 1/2", busy, frame_idx);
                end
            end
        end
        next_cycle();
        abort = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_async_reset();
        int fr;
        program_cfg('{1, 2, 1, 6, 1, 1, 1, 3});
        next_cycle();
        num_frames = '0;
        start      = 1'b1;
        repeat (30) next_cycle();
        @(posedge xclk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx} !==
            {1'b0, ADDR_W'(0), 1'b0, ~H_POL, ~V_POL, 1'b0, 1'b0, FRM_W'(0)}) begin
            errors++;
            $display("FAIL async_reset: got en=%b addr=%0d href=%b hs=%b vs=%b busy=%b done=%b idx=%0d",
                     rd_en, rd_addr, href, hsync, vsync, busy, frame_done, frame_idx);
        end
        repeat (2) @(negedge xclk);
        rst_n = 1'b1;
        model_reset_bank();
        next_cycle();
        next_cycle();
        run_model(1, 0, 0, 0, 0, 0, 0, 0, 1'b0, fr);
        checks++;
        if (rd_cnt_q.size() !== 1 || rd_cnt_q[0] !== 25) begin
            errors++;
            $display("FAIL default_bank_reads: got %0d want 25",
                     (rd_cnt_q.size() > 0) ? rd_cnt_q[0] : -1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        abort      = 1'b0;
        num_frames = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        model_reset_bank();
        test_reset();
        test_basic_burst();
        test_random_runs();
        test_stop();
        test_hd_change();
        test_abort();
        test_start_abort();
        test_start_in_run();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
